msg_serializer: RTL

//  Downstream stage of the stream parser. Accepts one 37-byte parsed message
//  (296-bit bus plus packet-lost flag) per valid/ready handshake, then replays
//  it as ten 32-bit beats with byte-keep, last and lost sidebands.

---
 rtl/msg_serializer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/msg_serializer.sv
// msg_serializer: accepts one parsed message per valid/ready handshake and replays
// it as 32-bit beats (earliest byte in the top lane) with keep/last/lost sidebands.
module msg_serializer #(
  parameter int MSG_BYTES = 37,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  // Leftmost bit is the MSB of byte 0, so the first byte on the wire is msgIn[top -: 8].
  input  logic [MSG_BYTES*8-1:0] msgIn,
  input  logic                   msgIn_val,
  output logic                   msgIn_ready,
  input  logic                   msgIn_lost,
  output logic [31:0]            dataOut,
  output logic [3:0]             dataOut_keep,
  output logic                   dataOut_val,
  input  logic                   dataOut_ready,
  output logic                   dataOut_last,
  output logic                   dataOut_lost,
  input  logic                   clearCounters,
  output logic [CNT_W-1:0]       msgCount,
  output logic [CNT_W-1:0]       lostCount
);

  localparam int MSG_W     = MSG_BYTES * 8;
  localparam int NUM_BEATS = (MSG_BYTES + 3) / 4;
  localparam int PAD_W     = NUM_BEATS * 32 - MSG_W;
  localparam int BUF_W     = NUM_BEATS * 32;
  localparam int IDX_W     = $clog2(NUM_BEATS);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BEATS - 1);
  // Valid lanes in the final beat fill from bit 3 downward.
  localparam logic [3:0]       LAST_KEEP = 4'(4'hF << (NUM_BEATS * 4 - MSG_BYTES));

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic               lost_q, lost_d;
  logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0]   lost_cnt_q, lost_cnt_d;

  logic               accept;
  logic               beat_fire;
  logic               last_beat;
  logic [BUF_W-1:0]   msg_padded;
  logic [31:0]        beat_data;

  assign accept     = msgIn_val && msgIn_ready;
  assign beat_fire  = dataOut_val && dataOut_ready;
  assign last_beat  = (idx_q == LAST_IDX);
  assign msg_padded = {msg_q, {PAD_W{1'b0}}};
  assign msgCount   = msg_cnt_q;
  assign lostCount  = lost_cnt_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next-state logic
  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (beat_fire && last_beat && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. In IDLE every beat sideband is driven low.
  always_comb begin
    msgIn_ready  = 1'b0;
    dataOut_val  = 1'b0;
    dataOut      = '0;
    dataOut_keep = '0;
    dataOut_last = 1'b0;
    dataOut_lost = 1'b0;
    case (state_q)
      IDLE: msgIn_ready = 1'b1;
      SEND: begin
        // Combinational from dataOut_ready so a new message can follow gap-free.
        msgIn_ready  = last_beat && dataOut_ready;
        dataOut_val  = 1'b1;
        dataOut      = beat_data;
        dataOut_keep = last_beat ? LAST_KEEP : 4'hF;
        dataOut_last = last_beat;
        dataOut_lost = lost_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat selection from the held message
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_data = '0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (idx_q == IDX_W'(k)) beat_data = msg_padded[BUF_W-1-32*k -: 32];
    end
  end

  // ---------------------------------------------------------------------------
  // Held message, beat index and lost flag
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d  = idx_q;
    msg_d  = msg_q;
    lost_d = lost_q;
    if (accept) begin
      idx_d  = '0;
      msg_d  = msgIn;
      lost_d = msgIn_lost;
    end else if (beat_fire) begin
      idx_d = last_beat ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      lost_q <= lost_d;
    end
  end

  // NOTE: the wide message register has no reset; its contents only reach the
  // outputs in SEND, which is entered solely through an accept that loads it.
  always_ff @(posedge clk) begin
    msg_q <= msg_d;
  end

  // ---------------------------------------------------------------------------
  // Saturating status counters; a clear still counts a same-edge accept.
  // ---------------------------------------------------------------------------
  always_comb begin
    msg_cnt_d  = msg_cnt_q;
    lost_cnt_d = lost_cnt_q;
    if (clearCounters) begin
      msg_cnt_d  = CNT_W'(accept);
      lost_cnt_d = CNT_W'(accept && msgIn_lost);
    end else begin
      if (accept && (msg_cnt_q != '1))                msg_cnt_d  = msg_cnt_q + 1'b1;
      if (accept && msgIn_lost && (lost_cnt_q != '1)) lost_cnt_d = lost_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_cnt_q  <= '0;
      lost_cnt_q <= '0;
    end else begin
      msg_cnt_q  <= msg_cnt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

endmodule
